// File: rtl/stopwatch_cu.sv
// -----------------------------------------------------------------------------
// stopwatch_cu
// Control unit for the stopwatch datapath. Run/stop and clear requests come
// from two sources: the debounced buttons and command bytes from the UART
// receiver. This block merges them and steps a STOP/RUN/CLEAR state machine
// that drives the datapath's runstop and clear inputs.
//
// Ports
//   clk            in   1  system clock
//   rst            in   1  synchronous, active-high reset
//   i_btn_runstop  in   1  one-cycle pulse: toggle run/stop
//   i_btn_clear    in   1  one-cycle pulse: clear the counters
//   i_rx_data      in   8  received UART byte, valid while i_rx_done=1
//   i_rx_done      in   1  one-cycle strobe: i_rx_data holds a new byte
//   o_runstop      out  1  1 = datapath counting enabled
//   o_clear        out  1  1 = datapath counters forced to zero
//   o_state        out  2  current state (00 STOP, 01 RUN, 10 CLEAR)
//   o_cmd_ack      out  1  one-cycle pulse: UART byte was a known command
//   o_cmd_err      out  1  one-cycle pulse: UART byte was not a command
//
// Parameters
//   CLEAR_CYCLES   number of cycles o_clear stays high per clear (>= 1)
// -----------------------------------------------------------------------------
module stopwatch_cu #(
    parameter int CLEAR_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_runstop,
    input  logic       i_btn_clear,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_done,
    output logic       o_runstop,
    output logic       o_clear,
    output logic [1:0] o_state,
    output logic       o_cmd_ack,
    output logic       o_cmd_err
);

    localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] clr_count;
    logic [CNT_W-1:0] next_count;

    logic rx_runstop;
    logic rx_clear;
    logic rx_known;
    logic ev_rs;
    logic ev_clr;

    // Decode the UART byte into events and merge with the buttons. An OR
    // merge means a button and a UART command asking for the same action in
    // one cycle collapse into a single event rather than toggling twice.
    always_comb begin
        rx_runstop = i_rx_done && (i_rx_data == 8'h52 || i_rx_data == 8'h72);
        rx_clear   = i_rx_done && (i_rx_data == 8'h43 || i_rx_data == 8'h63);
        rx_known   = rx_runstop || rx_clear;
        ev_rs      = i_btn_runstop || rx_runstop;
        ev_clr     = i_btn_clear || rx_clear;
    end

    // Next-state logic. Clearing is only allowed from STOP and beats a
    // simultaneous run request. While clearing, every event is discarded so
    // a press during the clear pulse has no delayed effect. The unused
    // encoding 11 falls back to STOP.
    always_comb begin
        next_state = state;
        next_count = '0;
        case (state)
            ST_STOP: begin
                if (ev_clr) begin
                    next_state = ST_CLEAR;
                end else if (ev_rs) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ev_rs) begin
                    next_state = ST_STOP;
                end
            end
            ST_CLEAR: begin
                if (clr_count == CNT_LAST) begin
                    next_state = ST_STOP;
                end else begin
                    next_count = clr_count + CNT_W'(1);
                end
            end
            default: begin
                next_state = ST_STOP;
            end
        endcase
    end

    // State, clear counter and all outputs are registered together. The
    // outputs are decoded from next_state so they line up with the state
    // register and never glitch; reset overrides every pending event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_STOP;
            clr_count <= '0;
            o_runstop <= 1'b0;
            o_clear   <= 1'b0;
            o_state   <= 2'b00;
            o_cmd_ack <= 1'b0;
            o_cmd_err <= 1'b0;
        end else begin
            state     <= next_state;
            clr_count <= next_count;
            o_runstop <= (next_state == ST_RUN);
            o_clear   <= (next_state == ST_CLEAR);
            o_state   <= next_state;
            o_cmd_ack <= i_rx_done && rx_known;
            o_cmd_err <= i_rx_done && !rx_known;
        end
    end

endmodule

// File: tb/tb_stopwatch_cu.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_cu
// Self-checking bench for stopwatch_cu. A stimulus process drives one input
// vector per cycle and pushes the expected outputs, produced by a behavioural
// model, into a queue. A separate monitor pops one entry per cycle on the
// falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_stopwatch_cu;

    localparam int CLEAR_CYCLES = 2;
    localparam int RANDOM_CYCLES = 10000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_btn_runstop = 1'b0;
    logic       i_btn_clear = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_done = 1'b0;
    logic       o_runstop;
    logic       o_clear;
    logic [1:0] o_state;
    logic       o_cmd_ack;
    logic       o_cmd_err;

    stopwatch_cu #(.CLEAR_CYCLES(CLEAR_CYCLES)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_btn_runstop (i_btn_runstop),
        .i_btn_clear   (i_btn_clear),
        .i_rx_data     (i_rx_data),
        .i_rx_done     (i_rx_done),
        .o_runstop     (o_runstop),
        .o_clear       (o_clear),
        .o_state       (o_state),
        .o_cmd_ack     (o_cmd_ack),
        .o_cmd_err     (o_cmd_err)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    typedef struct packed {
        logic       runstop;
        logic       clear;
        logic [1:0] state;
        logic       ack;
        logic       err;
    } expect_t;

    expect_t exp_q[$];
    expect_t pending;
    bit      pending_valid = 1'b0;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model: the stopwatch mode plus how many clear cycles remain.
    // 0 = stopped, 1 = running, 2 = clearing.
    int model_mode = 0;
    int model_clear_left = 0;

    task automatic checkOutput(input string name, input logic [1:0] actual,
                               input logic [1:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual,
                     expected, $time);
        end
    endtask

    // Drive one cycle of inputs and record what the DUT should show after the
    // next rising edge. The previous cycle's expectation is queued only now,
    // so the monitor's falling-edge pop always sees outputs it can judge.
    task automatic applyStimulus(input bit r, input bit brs, input bit bclr,
                                 input bit done, input logic [7:0] data);
        bit cmd_rs;
        bit cmd_clr;
        bit ev_rs;
        bit ev_clr;
        @(posedge clk);
        #1;
        if (pending_valid) exp_q.push_back(pending);
        rst           = r;
        i_btn_runstop = brs;
        i_btn_clear   = bclr;
        i_rx_done     = done;
        i_rx_data     = data;

        cmd_rs  = done && (data == "R" || data == "r");
        cmd_clr = done && (data == "C" || data == "c");
        ev_rs   = brs || cmd_rs;
        ev_clr  = bclr || cmd_clr;

        if (r) begin
            model_mode = 0;
            model_clear_left = 0;
        end else if (model_mode == 2) begin
            model_clear_left--;
            if (model_clear_left == 0) model_mode = 0;
        end else if (model_mode == 0) begin
            if (ev_clr) begin
                model_mode = 2;
                model_clear_left = CLEAR_CYCLES;
            end else if (ev_rs) begin
                model_mode = 1;
            end
        end else if (ev_rs) begin
            model_mode = 0;
        end

        pending.runstop = (model_mode == 1);
        pending.clear   = (model_mode == 2);
        pending.state   = 2'(model_mode);
        pending.ack     = !r && done && (cmd_rs || cmd_clr);
        pending.err     = !r && done && !(cmd_rs || cmd_clr);
        pending_valid   = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 8'h00);
    endtask

    // Monitor: compare one queued expectation per cycle, away from the
    // rising edge, and confirm run and clear are never asserted together.
    always @(negedge clk) begin
        expect_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("o_runstop", {1'b0, o_runstop}, {1'b0, e.runstop});
            checkOutput("o_clear", {1'b0, o_clear}, {1'b0, e.clear});
            checkOutput("o_state", o_state, e.state);
            checkOutput("o_cmd_ack", {1'b0, o_cmd_ack}, {1'b0, e.ack});
            checkOutput("o_cmd_err", {1'b0, o_cmd_err}, {1'b0, e.err});
            checkOutput("run_clear_exclusive", {1'b0, o_runstop & o_clear}, 2'b00);
        end
    end

    // Pick a random UART byte biased towards the command characters.
    function automatic logic [7:0] randomByte();
        case ($urandom_range(0, 5))
            0: return 8'h52;
            1: return 8'h72;
            2: return 8'h43;
            3: return 8'h63;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        // Two reset cycles, run at cycle 5, stop again at cycle 20.
        applyStimulus(1, 0, 0, 0, 8'h00);
        applyStimulus(1, 0, 0, 0, 8'h00);
        idle(2);
        applyStimulus(0, 1, 0, 0, 8'h00);
        idle(14);
        applyStimulus(0, 1, 0, 0, 8'h00);
        idle(3);

        // Clear from STOP; run press during the clear pulse is dropped.
        applyStimulus(0, 0, 1, 0, 8'h00);
        applyStimulus(0, 1, 0, 0, 8'h00);
        applyStimulus(0, 0, 1, 0, 8'h00);
        idle(3);

        // UART: 'R' starts, 'c' while running is ignored, 'A' is an error.
        applyStimulus(0, 0, 0, 1, 8'h52);
        idle(1);
        applyStimulus(0, 0, 0, 1, 8'h63);
        idle(1);
        applyStimulus(0, 0, 0, 1, 8'h41);
        idle(1);
        applyStimulus(0, 0, 0, 1, 8'h72);
        idle(2);

        // Same-cycle merges in STOP.
        applyStimulus(0, 1, 0, 1, 8'h72);
        idle(2);
        applyStimulus(0, 1, 0, 0, 8'h00);
        idle(1);
        applyStimulus(0, 1, 1, 0, 8'h00);
        idle(3);
        applyStimulus(0, 1, 0, 1, 8'h43);
        idle(3);

        // Reset on the first clear cycle, and reset while running with a
        // competing event in the same cycle.
        applyStimulus(0, 0, 1, 0, 8'h00);
        applyStimulus(1, 0, 0, 0, 8'h00);
        idle(2);
        applyStimulus(0, 1, 0, 0, 8'h00);
        idle(2);
        applyStimulus(1, 1, 0, 1, 8'h52);
        idle(2);

        // Randomised traffic.
        for (int i = 0; i < RANDOM_CYCLES; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 11) == 0,
                          $urandom_range(0, 7) == 0,
                          randomByte());
        end
        idle(2);

        // Flush the last expectation and make sure the monitor drained it.
        @(posedge clk);
        #1;
        exp_q.push_back(pending);
        pending_valid = 1'b0;
        @(posedge clk);
        #1;
        check_count++;
        if (exp_q.size() == 0) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
